// File: rtl/reg_file_mp.sv
// Multi-read-port register file with two write ports and issue-time busy tracking.
// r0 is hardwired to zero. Same-cycle writes are bypassed to the read ports.
// A per-register busy bit marks a pending producer, and busy_cnt counts the set bits.
module reg_file_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Writes and allocations that target r0 are dropped here, so r0 never changes.
    logic w0_en;
    logic w1_en;
    logic alloc_ok;
    logic set_inc;
    logic clr0;
    logic clr1;

    assign w0_en    = we0 && (waddr0 != '0);
    assign w1_en    = we1 && (waddr1 != '0);
    assign alloc_ok = alloc_en && (alloc_addr != '0);

    // Register array update. Port 1 is the later stage, so its write lands last and wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w0_en) mem_q[waddr0] <= wdata0;
            if (w1_en) mem_q[waddr1] <= wdata1;
        end
    end

    // Next busy vector: writes retire producers, and a same-edge allocation re-arms the bit.
    always_comb begin
        busy_d = busy_q;
        if (w0_en)    busy_d[waddr0]     = 1'b0;
        if (w1_en)    busy_d[waddr1]     = 1'b0;
        if (alloc_ok) busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Count delta, derived from the same events. A bit cleared by both ports counts once.
    always_comb begin
        set_inc = alloc_ok && !busy_q[alloc_addr];
        clr0    = w0_en && busy_q[waddr0] && !(alloc_ok && (alloc_addr == waddr0));
        clr1    = w1_en && busy_q[waddr1] && !(alloc_ok && (alloc_addr == waddr1))
                  && !(w0_en && (waddr0 == waddr1));
        cnt_d   = cnt_q + CNT_W'(set_inc) - CNT_W'(clr0) - CNT_W'(clr1);
    end

    // Busy bits and their population counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Combinational read with write-through bypass. Bypass is suppressed in reset so
        // that every read returns zero while rst is high.
        always_comb begin
            rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
            rd_busy[k]                  = busy_q[ra];
            if (!rst && (ra != '0)) begin
                if (w0_en && (waddr0 == ra)) begin
                    rd_data[k*DATA_W +: DATA_W] = wdata0;
                    rd_busy[k]                  = 1'b0;
                end
                if (w1_en && (waddr1 == ra)) begin
                    rd_data[k*DATA_W +: DATA_W] = wdata1;
                    rd_busy[k]                  = 1'b0;
                end
            end
        end
    end

endmodule
